tx_serial_cfg: RTL and testbench
================================

TX_SERIAL_CFG -- requirements
Module: tx_serial_cfg

Interface
REQ-001 Parameter N_DADOS, 7, data bits per frame, legal range 5..8.
REQ-002 Parameter PARIDADE, 1, parity mode: 0 none, 1 odd, 2 even.
REQ-003 Parameter N_STOP, 1, stop bits per frame, 1 or 2.
REQ-004 Parameter DIV_TICK, 5208, clock cycles per bit period (50 MHz / 9600 baud), minimum 2.
REQ-005 Ports SHALL be:
- clock  in  1  single system clock; rising edge only.
- reset  in  1  asynchronous, active-low.
- partida  in  1  transmit request, rising-edge detected.
- dados_ascii  in  N_DADOS  character to send.
- saida_serial  out  1  serial line, idle high.
- pronto  out  1  one-cycle pulse at end of frame.
- ocupado  out  1  high from frame start until the pronto cycle inclusive.

Function
REQ-006 The block SHALL use the states REPOUSO, INICIO, DADOS, BIT_PARIDADE, PARADA and FINAL.
REQ-007 In REPOUSO, saida_serial SHALL be 1 and ocupado SHALL be 0.
REQ-008 A 0->1 transition of partida, sampled on clock, in REPOUSO SHALL latch dados_ascii and enter INICIO on the next edge; saida_serial SHALL go low in that same cycle, giving 1-cycle latency.
REQ-009 partida held high SHALL produce exactly one frame.
REQ-010 Rising edges of partida while ocupado=1 SHALL be ignored, not queued.
REQ-011 Each bit SHALL last exactly DIV_TICK cycles, timed by a tick counter cleared on entry to INICIO.
REQ-012 Frame order SHALL be: start bit 0, then N_DADOS data bits LSB first, then the parity bit if PARIDADE!=0, then N_STOP stop bits at 1.
REQ-013 Odd parity SHALL make the count of ones across data plus parity odd; even parity SHALL make it even.
REQ-014 dados_ascii changes after the latch SHALL NOT affect the frame in progress.
REQ-015 After the last stop-bit period the block SHALL enter FINAL for one cycle with pronto=1 and saida_serial=1, then return to REPOUSO.
REQ-016 Frame length SHALL be (1+N_DADOS+(PARIDADE!=0)+N_STOP)*DIV_TICK cycles from the first 0 on the line to the pronto cycle, excluding the pronto cycle.
REQ-017 A partida rising edge in the cycle after FINAL SHALL start a new frame.

Reset
REQ-018 reset=0 SHALL immediately force REPOUSO, saida_serial=1, pronto=0, ocupado=0, counters=0 and the edge-detector register=0, including mid-frame.
REQ-019 After reset release, a partida already high SHALL NOT start a frame until it falls and rises again.

Configuration
REQ-020 With TX_SERIAL_DEBUG_EN defined, the block SHALL add the following outputs:
- db_tick  out  1  tick pulse.
- db_partida  out  1  registered partida.
- db_saida_serial  out  1  copy of saida_serial.
- db_estado  out  4  state code.
REQ-021 Without TX_SERIAL_DEBUG_EN, these ports and their logic SHALL be absent; functional behaviour SHALL be identical in both builds.

Structure
REQ-022 The package tx_serial_pkg SHALL hold the parity-mode constants (NENHUMA=0, IMPAR=1, PAR=2) and the 4-bit state codes:
- REPOUSO=0
- INICIO=1
- DADOS=2
- BIT_PARIDADE=3
- PARADA=4
- FINAL=5
REQ-023 The bit-timing counter SHALL be the sub-module contador_tick, parameter DIV_TICK, with a clear input and a one-cycle tick output.
REQ-024 Datapath (shift register, bit counter, parity accumulator) and FSM SHALL reside in tx_serial_cfg.

Verification (bench DIV_TICK=4, 50 MHz clock)
REQ-025 Config 7-1-1 (N_DADOS=7, odd parity, 1 stop), data 0x35:
- Line SHALL read 0,1,0,1,0,1,1,0,1,1, each bit 4 cycles.
- pronto SHALL pulse once, 40 cycles after the line first goes low.
REQ-026 Config 8-0-2 (8 data bits, no parity, 2 stops), data 0xA5:
- Line SHALL read 0,1,0,1,0,0,1,0,1,1,1 (11 bits, 44 cycles).
- ocupado SHALL be high for 45 cycles.
REQ-027 Config 7-2-1 (7 data bits, even parity, 1 stop), data 0x7F:
- Parity bit SHALL be 1.
- Config 7-1-1, data 0x7E: parity bit SHALL be 1.
REQ-028 partida held high for 25 cycles SHALL produce one frame only; a second rising edge mid-frame SHALL be ignored.
REQ-029 reset pulsed low during data bit 3 SHALL:
- set saida_serial=1 and ocupado=0 within the same cycle;
- produce no pronto pulse;
- allow a subsequent partida edge to send a correct full frame.

Source files
------------

// File: rtl/tx_serial_pkg.sv
// Shared constants for the configurable serial transmitter: parity modes and FSM state codes.
package tx_serial_pkg;

    localparam int NENHUMA = 0;
    localparam int IMPAR   = 1;
    localparam int PAR     = 2;

    typedef enum logic [3:0] {
        REPOUSO      = 4'd0,
        INICIO       = 4'd1,
        DADOS        = 4'd2,
        BIT_PARIDADE = 4'd3,
        PARADA       = 4'd4,
        FINAL        = 4'd5
    } estado_t;

endpackage

// File: rtl/contador_tick.sv
// Bit-period timer: free-running modulo-DIV_TICK counter with synchronous clear and a one-cycle tick.
module contador_tick #(
    parameter int DIV_TICK = 5208
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int W = (DIV_TICK > 1) ? $clog2(DIV_TICK) : 1;

    logic [W-1:0] cnt;

    // tick marks the last cycle of a bit period, so the FSM advances exactly DIV_TICK cycles after entry
    assign tick = (cnt == W'(DIV_TICK - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/tx_serial_cfg.sv
// Configurable asynchronous serial transmitter (start, N_DADOS data LSB first, optional parity, N_STOP stops).
// Defining TX_SERIAL_DEBUG_EN adds the db_* observation ports.
module tx_serial_cfg
    import tx_serial_pkg::*;
#(
    parameter int N_DADOS  = 7,
    parameter int PARIDADE = 1,
    parameter int N_STOP   = 1,
    parameter int DIV_TICK = 5208
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               partida,
    input  logic [N_DADOS-1:0] dados_ascii,
    output logic               saida_serial,
    output logic               pronto,
    output logic               ocupado
`ifdef TX_SERIAL_DEBUG_EN
    ,
    output logic               db_tick,
    output logic               db_partida,
    output logic               db_saida_serial,
    output logic [3:0]         db_estado
`endif
);

    estado_t            estado;
    logic               partida_q;
    logic               armado;
    logic [N_DADOS-1:0] shift;
    logic [2:0]         bit_cnt;
    logic               stop_cnt;
    logic               par_acc;
    logic               tick;
    logic               clear_tick;
    logic               inicio_pedido;

    // armado blocks a partida that was already high across reset until it has been seen low once
    assign inicio_pedido = partida && !partida_q && armado;
    assign clear_tick    = (estado == REPOUSO) || (estado == FINAL);

    contador_tick #(
        .DIV_TICK(DIV_TICK)
    ) u_contador_tick (
        .clock(clock),
        .reset(reset),
        .clear(clear_tick),
        .tick (tick)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado       <= REPOUSO;
            saida_serial <= 1'b1;
            pronto       <= 1'b0;
            ocupado      <= 1'b0;
            partida_q    <= 1'b0;
            armado       <= 1'b0;
            shift        <= '0;
            bit_cnt      <= '0;
            stop_cnt     <= 1'b0;
            par_acc      <= 1'b0;
        end else begin
            partida_q <= partida;
            if (!partida) armado <= 1'b1;
            pronto <= 1'b0;
            case (estado)
                REPOUSO: begin
                    saida_serial <= 1'b1;
                    ocupado      <= 1'b0;
                    if (inicio_pedido) begin
                        shift        <= dados_ascii;
                        par_acc      <= (PARIDADE == IMPAR);
                        bit_cnt      <= '0;
                        stop_cnt     <= 1'b0;
                        saida_serial <= 1'b0;
                        ocupado      <= 1'b1;
                        estado       <= INICIO;
                    end
                end
                INICIO: if (tick) begin
                    saida_serial <= shift[0];
                    par_acc      <= par_acc ^ shift[0];
                    shift        <= shift >> 1;
                    estado       <= DADOS;
                end
                DADOS: if (tick) begin
                    // par_acc already folds in every data bit by the time the last one finishes
                    if (bit_cnt == 3'(N_DADOS - 1)) begin
                        if (PARIDADE != NENHUMA) begin
                            saida_serial <= par_acc;
                            estado       <= BIT_PARIDADE;
                        end else begin
                            saida_serial <= 1'b1;
                            estado       <= PARADA;
                        end
                    end else begin
                        saida_serial <= shift[0];
                        par_acc      <= par_acc ^ shift[0];
                        shift        <= shift >> 1;
                        bit_cnt      <= bit_cnt + 3'd1;
                    end
                end
                BIT_PARIDADE: if (tick) begin
                    saida_serial <= 1'b1;
                    estado       <= PARADA;
                end
                PARADA: if (tick) begin
                    if (stop_cnt == 1'(N_STOP - 1)) begin
                        pronto <= 1'b1;
                        estado <= FINAL;
                    end else begin
                        stop_cnt <= stop_cnt + 1'b1;
                    end
                end
                FINAL: begin
                    saida_serial <= 1'b1;
                    ocupado      <= 1'b0;
                    estado       <= REPOUSO;
                end
                default: begin
                    saida_serial <= 1'b1;
                    ocupado      <= 1'b0;
                    estado       <= REPOUSO;
                end
            endcase
        end
    end

`ifdef TX_SERIAL_DEBUG_EN
    assign db_tick         = tick;
    assign db_partida      = partida_q;
    assign db_saida_serial = saida_serial;
    assign db_estado       = estado;
`endif

endmodule

// File: tb/tb_tx_serial_cfg.sv
// Directed bench: three transmitter configurations (7-odd-1, 8-none-2, 7-even-1) sharing clock and reset.
module tb_tx_serial_cfg;

    logic            clk;
    logic            rst_n;
    logic [2:0]      partida;
    logic [2:0][7:0] dados;
    wire  [2:0]      saida;
    wire  [2:0]      pronto;
    wire  [2:0]      ocupado;

    int n_checks;
    int n_pass;

    tx_serial_cfg #(.N_DADOS(7), .PARIDADE(1), .N_STOP(1), .DIV_TICK(4)) dut_7o1 (
        .clock(clk), .reset(rst_n), .partida(partida[0]), .dados_ascii(dados[0][6:0]),
        .saida_serial(saida[0]), .pronto(pronto[0]), .ocupado(ocupado[0])
    );

    tx_serial_cfg #(.N_DADOS(8), .PARIDADE(0), .N_STOP(2), .DIV_TICK(4)) dut_8n2 (
        .clock(clk), .reset(rst_n), .partida(partida[1]), .dados_ascii(dados[1]),
        .saida_serial(saida[1]), .pronto(pronto[1]), .ocupado(ocupado[1])
    );

    tx_serial_cfg #(.N_DADOS(7), .PARIDADE(2), .N_STOP(1), .DIV_TICK(4)) dut_7e1 (
        .clock(clk), .reset(rst_n), .partida(partida[2]), .dados_ascii(dados[2][6:0]),
        .saida_serial(saida[2]), .pronto(pronto[2]), .ocupado(ocupado[2])
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Sends one frame on instance idx starting at a negedge; exp_bits[b] is line bit b (bit 0 = start).
    task automatic run_frame(input int idx, input logic [7:0] data, input int nbits,
                             input logic [10:0] exp_bits, input int hold, input int re_rise,
                             input int idle_cyc, input string name);
        int cyc;
        int pr_cnt;
        int oc_cnt;
        cyc    = 0;
        pr_cnt = 0;
        oc_cnt = 0;
        dados[idx]   = data;
        partida[idx] = 1'b1;
        for (int b = 0; b < nbits; b++) begin
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                cyc++;
                n_checks++;
                if (saida[idx] !== exp_bits[b])
                    $display("FAIL %s bit%0d cyc%0d: line=%b expected=%b", name, b, c, saida[idx], exp_bits[b]);
                else
                    n_pass++;
                if (pronto[idx] === 1'b1) pr_cnt++;
                if (ocupado[idx] === 1'b1) oc_cnt++;
                if (cyc == 2) dados[idx] = ~data;
                if (cyc == hold) partida[idx] = 1'b0;
                if (re_rise >= 0 && cyc == re_rise) partida[idx] = 1'b1;
                if (re_rise >= 0 && cyc == re_rise + 2) partida[idx] = 1'b0;
            end
        end
        partida[idx] = 1'b0;
        @(negedge clk);
        if (ocupado[idx] === 1'b1) oc_cnt++;
        n_checks++;
        if (pronto[idx] !== 1'b1 || saida[idx] !== 1'b1)
            $display("FAIL %s final: pronto=%b line=%b expected pronto=1 line=1", name, pronto[idx], saida[idx]);
        else
            n_pass++;
        @(negedge clk);
        n_checks++;
        if (pronto[idx] !== 1'b0 || ocupado[idx] !== 1'b0 || saida[idx] !== 1'b1)
            $display("FAIL %s idle_after: pronto=%b ocupado=%b line=%b expected 0,0,1",
                     name, pronto[idx], ocupado[idx], saida[idx]);
        else
            n_pass++;
        n_checks++;
        if (pr_cnt != 0)
            $display("FAIL %s early_pronto: pulses=%0d expected=0", name, pr_cnt);
        else
            n_pass++;
        n_checks++;
        if (oc_cnt != nbits * 4 + 1)
            $display("FAIL %s ocupado_len: cycles=%0d expected=%0d", name, oc_cnt, nbits * 4 + 1);
        else
            n_pass++;
        for (int i = 0; i < idle_cyc; i++) begin
            @(negedge clk);
            n_checks++;
            if (saida[idx] !== 1'b1 || ocupado[idx] !== 1'b0 || pronto[idx] !== 1'b0)
                $display("FAIL %s idle%0d: line=%b ocupado=%b pronto=%b expected 1,0,0",
                         name, i, saida[idx], ocupado[idx], pronto[idx]);
            else
                n_pass++;
        end
    endtask

    task automatic test_reset;
        rst_n   = 1'b0;
        partida = '0;
        dados   = '0;
        #25;
        n_checks++;
        if (saida !== 3'b111 || pronto !== 3'b000 || ocupado !== 3'b000)
            $display("FAIL reset: line=%b pronto=%b ocupado=%b expected 111,000,000", saida, pronto, ocupado);
        else
            n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_frame_7o1;
        run_frame(0, 8'h35, 10, 11'b11101101010, 1, -1, 2, "7o1_35");
        run_frame(0, 8'h00, 10, 11'b11100000000, 3, -1, 2, "7o1_00");
    endtask

    task automatic test_frame_8n2;
        run_frame(1, 8'hA5, 11, 11'b11101001010, 1, -1, 2, "8n2_A5");
        run_frame(1, 8'hFF, 11, 11'b11111111110, 1, -1, 2, "8n2_FF");
    endtask

    task automatic test_parity;
        run_frame(2, 8'h7F, 10, 11'b11111111110, 1, -1, 2, "7e1_7F");
        run_frame(2, 8'h00, 10, 11'b11000000000, 1, -1, 2, "7e1_00");
        run_frame(0, 8'h7E, 10, 11'b11111111100, 1, -1, 2, "7o1_7E");
    endtask

    task automatic test_hold_and_ignore;
        run_frame(0, 8'h35, 10, 11'b11101101010, 25, 30, 20, "hold25");
    endtask

    task automatic test_back_to_back;
        run_frame(1, 8'hA5, 11, 11'b11101001010, 2, -1, 0, "b2b_first");
        run_frame(1, 8'hFF, 11, 11'b11111111110, 2, -1, 2, "b2b_second");
    endtask

    task automatic test_reset_mid_frame;
        int pr_cnt;
        int bad;
        pr_cnt = 0;
        bad    = 0;
        dados[0]   = 8'h35;
        partida[0] = 1'b1;
        for (int cyc = 1; cyc <= 18; cyc++) begin
            @(negedge clk);
            if (cyc == 2) partida[0] = 1'b0;
            if (pronto[0] === 1'b1) pr_cnt++;
        end
        n_checks++;
        if (saida[0] !== 1'b0 || ocupado[0] !== 1'b1)
            $display("FAIL rst_mid bit3: line=%b ocupado=%b expected 0,1", saida[0], ocupado[0]);
        else
            n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (saida[0] !== 1'b1 || ocupado[0] !== 1'b0 || pronto[0] !== 1'b0)
            $display("FAIL rst_mid immediate: line=%b ocupado=%b pronto=%b expected 1,0,0",
                     saida[0], ocupado[0], pronto[0]);
        else
            n_pass++;
        partida[0] = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (pronto[0] === 1'b1) pr_cnt++;
            if (saida[0] !== 1'b1 || ocupado[0] !== 1'b0) bad++;
        end
        n_checks++;
        if (pr_cnt != 0)
            $display("FAIL rst_mid pronto: pulses=%0d expected=0", pr_cnt);
        else
            n_pass++;
        n_checks++;
        if (bad != 0)
            $display("FAIL rst_mid held_partida: busy_cycles=%0d expected=0", bad);
        else
            n_pass++;
        partida[0] = 1'b0;
        repeat (2) @(negedge clk);
        run_frame(0, 8'h35, 10, 11'b11101101010, 1, -1, 2, "after_rst");
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_frame_7o1();
        test_frame_8n2();
        test_parity();
        test_hold_and_ignore();
        test_back_to_back();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
